melody_memory_core: RTL and testbench
=====================================

Name: melody_memory_core

Overview:
- Parametrised successor to the fixed 8-note "listen and repeat" game core.
- Stores a loaded melody and plays a growing prefix of it as tones.
- Checks the player's key presses against that prefix and tracks lives, level and win/lose.
- Sits between the bus write port and keypad decoder upstream, and the piezo/LED drivers downstream.

Parameters:
NOTE_W, 3, bits per stored note; stored value v plays as code v+1 (0 = silence)
SEQ_MAX, 8, maximum melody length (winning length)
START_LEN, 3, prefix length of level 1; 1 <= START_LEN <= SEQ_MAX
TICK_DIV, 5000000, clk cycles per tick
ON_TICKS, 2, ticks a played note sounds
OFF_TICKS, 1, silent ticks after each played note
GAP_TICKS, 4, silent ticks before each replay
LIVES, 3, misses allowed per game; >= 1
WAIT_TICKS, 0, input timeout in ticks; 0 disables timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
load_valid  in  1  one-cycle pulse, capture load_data
load_data  in  SEQ_MAX*NOTE_W  melody; note i in bits [i*NOTE_W +: NOTE_W]
start  in  1  one-cycle pulse, begin game
key_valid  in  1  one-cycle pulse per key press
key_code  in  NOTE_W+1  pressed note code, 1..2^NOTE_W
note_out  out  NOTE_W+1  tone/LED code, 0 = silent
playing  out  1  melody playback in progress
awaiting_input  out  1  accepting keys
miss  out  1  one-cycle pulse on wrong key or timeout
lives_left  out  $clog2(LIVES+1)  remaining lives
level  out  $clog2(SEQ_MAX+1)  current prefix length, 0 in IDLE
game_over  out  1  game finished
game_win  out  1  finished by completing SEQ_MAX

Behaviour:
- Reset values:
  - Outputs: note_out 0, playing 0, awaiting_input 0, miss 0, lives_left LIVES, level 0, game_over 0, game_win 0.
  - Internal: FSM to IDLE; melody-loaded flag cleared; tick counter cleared.
- Reset asserted mid-game aborts immediately; no state survives.
- Tick: a pulse every TICK_DIV cycles. The counter restarts at 0 on every entry to PLAY_ON, PLAY_OFF, ECHO, GAP and WAIT_KEY, so each state lasts exactly N*TICK_DIV cycles.
- load_valid: accepted only in IDLE or DONE; sets the loaded flag; ignored elsewhere.
- start: accepted only in IDLE or DONE with the loaded flag set; ignored otherwise.
- load_valid and start in the same cycle: the load wins, and start uses the new data.
- FSM:
  - IDLE -> (start) PLAY_ON: idx=0, level=START_LEN, lives_left=LIVES, game_over=0, game_win=0.
  - PLAY_ON: note_out = note[idx]+1, playing=1, for ON_TICKS ticks -> PLAY_OFF.
  - PLAY_OFF: note_out=0 for OFF_TICKS ticks.
    - If idx==level-1: -> WAIT_KEY, idx=0, playing=0.
    - Else: idx+1 -> PLAY_ON.
  - WAIT_KEY: awaiting_input=1.
    - key_valid with key_code != 0 is accepted. Compare against note[idx]+1 in the same cycle and register the result. -> ECHO.
    - key_code == 0 is ignored.
  - ECHO: note_out = accepted key_code for ON_TICKS ticks, awaiting_input=0; keys ignored. Then:
    - Correct, idx<level-1: idx+1 -> WAIT_KEY.
    - Correct, idx==level-1, level<SEQ_MAX: level+1, idx=0 -> GAP.
    - Correct, idx==level-1, level==SEQ_MAX: -> DONE, game_win=1.
    - Wrong: miss pulses in the first ECHO cycle, lives_left-1. If lives_left reaches 0 -> DONE (game_win=0); else idx=0 -> GAP, replaying the same level.
  - Timeout: when WAIT_TICKS>0 and WAIT_TICKS ticks elapse in WAIT_KEY with no accepted key, it is treated as a wrong key: miss pulse, no ECHO, same branch as Wrong.
  - GAP: note_out=0 for GAP_TICKS ticks -> PLAY_ON, idx=0.
  - DONE: game_over=1; level holds its final value.
- Keys outside WAIT_KEY are dropped; they are never queued.
- lives_left and level never wrap: lives_left saturates at 0, and level at SEQ_MAX.

Optional Feature:
TEMPO_RAMP_EN
- Defined: effective ON_TICKS = max(1, ON_TICKS - (level - START_LEN)), re-evaluated at each entry to PLAY_ON. ECHO duration is unchanged.
- Undefined: ON_TICKS is constant for all levels.

Test Plan:
Bench parameters: NOTE_W=3, SEQ_MAX=4, START_LEN=3, TICK_DIV=2, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=1, LIVES=2, WAIT_TICKS=0.

1. Load 12'h688 (notes 0,1,2,3), start -> note_out 1 for 4 cycles, 0 for 2, then 2, 0, 3, 0. Then awaiting_input=1, level=3, playing=0.
2. After 1, keys 1,2,3 -> level=4, GAP 2 cycles, playback 1,2,3,4. Keys 1,2,3,4 -> game_over=1, game_win=1.
3. After 1, key 2 -> miss for 1 cycle, lives_left=1, replay at level 3. Key 4 -> miss, lives_left=0, game_over=1, game_win=0.
4. key_valid during PLAY_ON, and start mid-game -> no effect on idx, lives_left or note_out sequence.
5. reset pulsed mid-PLAY_ON -> all outputs at reset values. A following start without load_valid -> stays IDLE.
6. WAIT_TICKS=3 build: no key for 6 cycles in WAIT_KEY -> miss pulse, lives_left=1, GAP then replay. TEMPO_RAMP_EN build: level-4 notes last 2 cycles.

Source files
------------

// File: rtl/melody_memory_core.sv
// melody_memory_core: listen-and-repeat melody game core (load, play prefix, check keys).
// Optional macro TEMPO_RAMP_EN: played notes shorten by one tick per level gained.
module melody_memory_core #(
    parameter int NOTE_W     = 3,
    parameter int SEQ_MAX    = 8,
    parameter int START_LEN  = 3,
    parameter int TICK_DIV   = 5000000,
    parameter int ON_TICKS   = 2,
    parameter int OFF_TICKS  = 1,
    parameter int GAP_TICKS  = 4,
    parameter int LIVES      = 3,
    parameter int WAIT_TICKS = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_valid,
    input  logic [SEQ_MAX*NOTE_W-1:0]   load_data,
    input  logic                        start,
    input  logic                        key_valid,
    input  logic [NOTE_W:0]             key_code,
    output logic [NOTE_W:0]             note_out,
    output logic                        playing,
    output logic                        awaiting_input,
    output logic                        miss,
    output logic [$clog2(LIVES+1)-1:0]  lives_left,
    output logic [$clog2(SEQ_MAX+1)-1:0] level,
    output logic                        game_over,
    output logic                        game_win
);

    localparam int IW  = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam int LVW = $clog2(SEQ_MAX + 1);
    localparam int LW  = $clog2(LIVES + 1);
    localparam int DW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int M1  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int M2  = (M1 > GAP_TICKS) ? M1 : GAP_TICKS;
    localparam int M3  = (M2 > WAIT_TICKS) ? M2 : WAIT_TICKS;
    localparam int TW  = $clog2(M3 + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY_ON,
        S_PLAY_OFF,
        S_WAIT_KEY,
        S_ECHO,
        S_GAP,
        S_DONE
    } state_t;

    state_t                    state_q;
    logic [SEQ_MAX*NOTE_W-1:0] mel_q;
    logic                      loaded_q;
    logic [DW-1:0]             div_q;
    logic [TW-1:0]             tcnt_q;
    logic [TW-1:0]             on_len_q;
    logic [IW-1:0]             idx_q;
    logic                      ok_q;
    logic [NOTE_W:0]           note_q;
    logic                      playing_q;
    logic                      await_q;
    logic                      miss_q;
    logic [LW-1:0]             lives_q;
    logic [LVW-1:0]            level_q;
    logic                      over_q;
    logic                      win_q;

    logic [NOTE_W-1:0] notes [SEQ_MAX];
    logic [NOTE_W:0]   cur_tone;
    logic [NOTE_W:0]   nxt_tone;
    logic [NOTE_W:0]   first_tone;
    logic [NOTE_W:0]   start_tone;
    logic [IW-1:0]     nxt_idx;
    logic              tick;
    logic              expire;
    logic              last;
    logic              key_ok;
    logic              can_cfg;
    int                dur;
    logic [TW-1:0]     on_len;

    function automatic logic [NOTE_W:0] tone(input logic [NOTE_W-1:0] n);
        return {1'b0, n} + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < SEQ_MAX; i++) begin
            notes[i] = mel_q[i*NOTE_W +: NOTE_W];
        end
    end

    assign nxt_idx    = idx_q + 1'b1;
    assign cur_tone   = tone(notes[idx_q]);
    assign nxt_tone   = tone(notes[nxt_idx]);
    assign first_tone = tone(notes[0]);
    assign start_tone = tone(load_valid ? load_data[NOTE_W-1:0]
                                        : mel_q[NOTE_W-1:0]);
    assign key_ok     = (key_code == cur_tone);
    assign last       = (int'(idx_q) == int'(level_q) - 1);
    assign can_cfg    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign tick       = (div_q == DW'(TICK_DIV - 1));

`ifdef TEMPO_RAMP_EN
    int ramp;
    // Level entering PLAY_ON: START_LEN on a fresh start, level_q otherwise.
    always_comb begin
        ramp = ON_TICKS - (can_cfg ? 0 : int'(level_q) - START_LEN);
        if (ramp < 1) ramp = 1;
    end
    assign on_len = TW'(ramp);
`else
    assign on_len = TW'(ON_TICKS);
`endif

    always_comb begin
        dur = 0;
        unique case (state_q)
            S_PLAY_ON:  dur = int'(on_len_q);
            S_PLAY_OFF: dur = OFF_TICKS;
            S_ECHO:     dur = ON_TICKS;
            S_GAP:      dur = GAP_TICKS;
            S_WAIT_KEY: dur = WAIT_TICKS;
            default:    dur = 0;
        endcase
    end

    // dur of 0 never matches, which also disables the key timeout.
    assign expire = tick && (int'(tcnt_q) == dur - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mel_q     <= '0;
            loaded_q  <= 1'b0;
            div_q     <= '0;
            tcnt_q    <= '0;
            on_len_q  <= TW'(ON_TICKS);
            idx_q     <= '0;
            ok_q      <= 1'b0;
            note_q    <= '0;
            playing_q <= 1'b0;
            await_q   <= 1'b0;
            miss_q    <= 1'b0;
            lives_q   <= LW'(LIVES);
            level_q   <= '0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            miss_q <= 1'b0;
            if (tick) begin
                div_q  <= '0;
                tcnt_q <= tcnt_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    div_q  <= '0;
                    tcnt_q <= '0;
                    if (load_valid) begin
                        mel_q    <= load_data;
                        loaded_q <= 1'b1;
                    end
                    if (start && (loaded_q || load_valid)) begin
                        state_q   <= S_PLAY_ON;
                        idx_q     <= '0;
                        level_q   <= LVW'(START_LEN);
                        lives_q   <= LW'(LIVES);
                        over_q    <= 1'b0;
                        win_q     <= 1'b0;
                        note_q    <= start_tone;
                        playing_q <= 1'b1;
                        on_len_q  <= on_len;
                    end
                end
                S_PLAY_ON: begin
                    if (expire) begin
                        div_q   <= '0;
                        tcnt_q  <= '0;
                        state_q <= S_PLAY_OFF;
                        note_q  <= '0;
                    end
                end
                S_PLAY_OFF: begin
                    if (expire) begin
                        div_q  <= '0;
                        tcnt_q <= '0;
                        if (last) begin
                            state_q   <= S_WAIT_KEY;
                            idx_q     <= '0;
                            playing_q <= 1'b0;
                            await_q   <= 1'b1;
                        end else begin
                            state_q  <= S_PLAY_ON;
                            idx_q    <= nxt_idx;
                            note_q   <= nxt_tone;
                            on_len_q <= on_len;
                        end
                    end
                end
                S_WAIT_KEY: begin
                    if (key_valid && (key_code != '0)) begin
                        div_q   <= '0;
                        tcnt_q  <= '0;
                        state_q <= S_ECHO;
                        ok_q    <= key_ok;
                        note_q  <= key_code;
                        await_q <= 1'b0;
                        if (!key_ok) begin
                            miss_q <= 1'b1;
                            if (lives_q != '0) lives_q <= lives_q - 1'b1;
                        end
                    end else if (expire) begin
                        div_q   <= '0;
                        tcnt_q  <= '0;
                        await_q <= 1'b0;
                        miss_q  <= 1'b1;
                        idx_q   <= '0;
                        if (lives_q <= LW'(1)) begin
                            lives_q <= '0;
                            state_q <= S_DONE;
                            over_q  <= 1'b1;
                            win_q   <= 1'b0;
                        end else begin
                            lives_q <= lives_q - 1'b1;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_ECHO: begin
                    if (expire) begin
                        div_q  <= '0;
                        tcnt_q <= '0;
                        note_q <= '0;
                        if (ok_q && !last) begin
                            idx_q   <= nxt_idx;
                            state_q <= S_WAIT_KEY;
                            await_q <= 1'b1;
                        end else if (ok_q && (level_q < LVW'(SEQ_MAX))) begin
                            level_q <= level_q + 1'b1;
                            idx_q   <= '0;
                            state_q <= S_GAP;
                        end else if (ok_q) begin
                            state_q <= S_DONE;
                            over_q  <= 1'b1;
                            win_q   <= 1'b1;
                        end else if (lives_q == '0) begin
                            state_q <= S_DONE;
                            over_q  <= 1'b1;
                            win_q   <= 1'b0;
                        end else begin
                            idx_q   <= '0;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (expire) begin
                        div_q     <= '0;
                        tcnt_q    <= '0;
                        state_q   <= S_PLAY_ON;
                        idx_q     <= '0;
                        note_q    <= first_tone;
                        playing_q <= 1'b1;
                        on_len_q  <= on_len;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign note_out       = note_q;
    assign playing        = playing_q;
    assign awaiting_input = await_q;
    assign miss           = miss_q;
    assign lives_left     = lives_q;
    assign level          = level_q;
    assign game_over      = over_q;
    assign game_win       = win_q;

endmodule

// File: tb/tb_melody_memory_core.sv
// tb_melody_memory_core: scenario table, hand sequences and random games
// checked against a rule-level model of the melody game.
`timescale 1ns/1ps
module tb_melody_memory_core;

    localparam int NW  = 3;
    localparam int SM  = 4;
    localparam int SL  = 3;
    localparam int TD  = 2;
    localparam int ON  = 2;
    localparam int OFF = 1;
    localparam int GP  = 1;
    localparam int LV  = 2;
    localparam int MW  = SM * NW;
    localparam int KW  = NW + 1;
`ifdef TEMPO_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic          start = 1'b0;
    logic          key_valid = 1'b0;
    logic [MW-1:0] load_data = '0;
    logic [KW-1:0] key_code = '0;
    logic [KW-1:0] note_out;
    logic          playing, awaiting_input, miss, game_over, game_win;
    logic [1:0]    lives_left;
    logic [2:0]    level;

    logic          ld2 = 1'b0;
    logic          st2 = 1'b0;
    logic          kv2 = 1'b0;
    logic [KW-1:0] kc2 = '0;
    logic [KW-1:0] note_t;
    logic          play_t, await_t, miss_t, over_t, win_t;
    logic [1:0]    lives_t;
    logic [2:0]    level_t;

    melody_memory_core #(
        .NOTE_W(NW), .SEQ_MAX(SM), .START_LEN(SL), .TICK_DIV(TD),
        .ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GP), .LIVES(LV),
        .WAIT_TICKS(0)
    ) u_dut (
        .clk(clk), .reset(reset), .load_valid(load_valid),
        .load_data(load_data), .start(start), .key_valid(key_valid),
        .key_code(key_code), .note_out(note_out), .playing(playing),
        .awaiting_input(awaiting_input), .miss(miss),
        .lives_left(lives_left), .level(level),
        .game_over(game_over), .game_win(game_win)
    );

    melody_memory_core #(
        .NOTE_W(NW), .SEQ_MAX(SM), .START_LEN(SL), .TICK_DIV(TD),
        .ON_TICKS(ON), .OFF_TICKS(OFF), .GAP_TICKS(GP), .LIVES(LV),
        .WAIT_TICKS(3)
    ) u_to (
        .clk(clk), .reset(reset), .load_valid(ld2),
        .load_data(load_data), .start(st2), .key_valid(kv2),
        .key_code(kc2), .note_out(note_t), .playing(play_t),
        .awaiting_input(await_t), .miss(miss_t),
        .lives_left(lives_t), .level(level_t),
        .game_over(over_t), .game_win(win_t)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] mel;
        logic [39:0]   keys;
        int            nkeys;
        bit            same;
        bit            win;
        int            lives;
        int            lvl;
    } scen_t;

    scen_t         tbl [4];
    int            n_tests = 0;
    int            n_fail = 0;
    logic [MW-1:0] mel_m;
    int            lvl_m;
    int            lives_m;
    bit            noise_en = 1'b0;
    bit            won_m;
    int            script_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int code_m(input int i);
        return int'(mel_m[i*NW +: NW]) + 1;
    endfunction

    function automatic int on_m(input int lvl);
        int t;
        if (!RAMP) return ON;
        t = ON - (lvl - SL);
        return (t < 1) ? 1 : t;
    endfunction

    task automatic clr_in();
        key_valid  = 1'b0;
        key_code   = '0;
        start      = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic drive_noise();
        clr_in();
        if (noise_en) begin
            key_valid  = 1'($urandom_range(0, 1));
            key_code   = KW'($urandom_range(0, 8));
            start      = ($urandom_range(0, 3) == 0);
            load_valid = ($urandom_range(0, 7) == 0);
            if (load_valid) load_data = MW'($urandom);
        end
    endtask

    task automatic next_key(input int i, output int k);
        if (script_q.size() > 0) k = script_q.pop_front();
        else if ($urandom_range(0, 3) != 0) k = code_m(i);
        else k = ((code_m(i) - 1 + int'($urandom_range(1, 7))) % 8) + 1;
    endtask

    task automatic start_game(input logic [MW-1:0] mel, input bit same);
        @(negedge clk);
        mel_m      = mel;
        load_data  = mel;
        load_valid = 1'b1;
        if (!same) begin
            @(negedge clk);
            load_valid = 1'b0;
        end
        start = 1'b1;
    endtask

    task automatic play_check(input int lvl);
        for (int i = 0; i < lvl; i++) begin
            for (int c = 0; c < on_m(lvl) * TD; c++) begin
                @(negedge clk);
                chk("play_note", note_out, code_m(i));
                chk("play_flag", playing, 1);
                chk("play_await", awaiting_input, 0);
                chk("play_level", level, lvl);
                chk("play_lives", lives_left, lives_m);
                drive_noise();
            end
            for (int c = 0; c < OFF * TD; c++) begin
                @(negedge clk);
                chk("play_off", note_out, 0);
                drive_noise();
            end
        end
        clr_in();
    endtask

    task automatic echo_check(input int k, input bit wrong);
        for (int c = 0; c < ON * TD; c++) begin
            @(negedge clk);
            chk("echo_note", note_out, k);
            chk("echo_miss", miss, (c == 0) ? int'(wrong) : 0);
            chk("echo_await", awaiting_input, 0);
            if (c == 0) chk("echo_lives", lives_left, lives_m);
            drive_noise();
        end
        clr_in();
    endtask

    task automatic gap_check();
        for (int c = 0; c < GP * TD; c++) begin
            @(negedge clk);
            chk("gap_note", note_out, 0);
            chk("gap_playing", playing, 0);
            chk("gap_miss", miss, 0);
            drive_noise();
        end
        clr_in();
    endtask

    task automatic play_game();
        bit ok_all;
        bit done;
        bit wrong;
        int k;
        lvl_m   = SL;
        lives_m = LV;
        done    = 1'b0;
        ok_all  = 1'b1;
        while (!done) begin
            play_check(lvl_m);
            ok_all = 1'b1;
            for (int i = 0; i < lvl_m && ok_all; i++) begin
                @(negedge clk);
                chk("wait_await", awaiting_input, 1);
                chk("wait_note", note_out, 0);
                chk("wait_playing", playing, 0);
                chk("wait_level", level, lvl_m);
                chk("wait_miss", miss, 0);
                if (script_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                    key_valid = 1'b1;
                    key_code  = '0;
                    @(negedge clk);
                    chk("zero_key_ignored", awaiting_input, 1);
                end
                next_key(i, k);
                key_valid = 1'b1;
                key_code  = KW'(k);
                wrong = (k != code_m(i));
                if (wrong) begin
                    lives_m--;
                    ok_all = 1'b0;
                end
                echo_check(k, wrong);
            end
            if ((!ok_all && lives_m == 0) || (ok_all && lvl_m == SM)) begin
                done = 1'b1;
            end else begin
                if (ok_all) lvl_m++;
                gap_check();
            end
        end
        won_m = ok_all;
        @(negedge clk);
        chk("done_over", game_over, 1);
        chk("done_win", game_win, int'(won_m));
        chk("done_level", level, lvl_m);
        chk("done_lives", lives_left, lives_m);
        chk("done_note", note_out, 0);
        chk("done_await", awaiting_input, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_note;
        int p;
        tbl[0] = '{12'h688, 40'h0004321321, 7, 1'b0, 1'b1, 2, 4};
        tbl[1] = '{12'h688, 40'h0000000042, 2, 1'b1, 1'b0, 0, 3};
        tbl[2] = '{12'h547, 40'h3618718618, 10, 1'b1, 1'b1, 1, 4};
        tbl[3] = '{12'h688, 40'h0000251321, 6, 1'b0, 1'b0, 0, 4};

        repeat (2) @(negedge clk);
        chk("rst_note", note_out, 0);
        chk("rst_playing", playing, 0);
        chk("rst_await", awaiting_input, 0);
        chk("rst_miss", miss, 0);
        chk("rst_lives", lives_left, LV);
        chk("rst_level", level, 0);
        chk("rst_over", game_over, 0);
        chk("rst_win", game_win, 0);
        reset = 1'b0;

        // start before any load is ignored
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("noload_level", level, 0);
        chk("noload_playing", playing, 0);

        // timeout build: no keys at all, two timeouts end the game
        @(negedge clk);
        load_data = 12'h688;
        ld2 = 1'b1;
        st2 = 1'b1;
        for (int c = 1; c <= 51; c++) begin
            @(negedge clk);
            ld2 = 1'b0;
            st2 = 1'b0;
            p = (c >= 27) ? c - 27 : c - 1;
            e_note = ((p % 6) < 4) ? (p / 6) + 1 : 0;
            if ((c >= 1 && c <= 18) || (c >= 27 && c <= 44)) begin
                chk("to_note", note_t, e_note);
                chk("to_miss", miss_t, 0);
            end else if ((c >= 19 && c <= 24) || (c >= 45 && c <= 50)) begin
                chk("to_await", await_t, 1);
                chk("to_wait_miss", miss_t, 0);
            end else if (c == 25) begin
                chk("to_miss1", miss_t, 1);
                chk("to_lives1", lives_t, 1);
                chk("to_await_off", await_t, 0);
            end else if (c == 26) begin
                chk("to_gap_note", note_t, 0);
                chk("to_miss_clr", miss_t, 0);
            end else begin
                chk("to_miss2", miss_t, 1);
                chk("to_lives0", lives_t, 0);
                chk("to_over", over_t, 1);
                chk("to_win", win_t, 0);
                chk("to_level", level_t, 3);
            end
        end

        for (int r = 0; r < 4; r++) begin
            noise_en = (r >= 2);
            script_q.delete();
            for (int j = 0; j < tbl[r].nkeys; j++) begin
                script_q.push_back(int'(tbl[r].keys[j*4 +: 4]));
            end
            start_game(tbl[r].mel, tbl[r].same);
            play_game();
            chk("tbl_win", game_win, int'(tbl[r].win));
            chk("tbl_lives", lives_left, tbl[r].lives);
            chk("tbl_level", level, tbl[r].lvl);
        end

        // reset in the middle of playback, then start without reload
        noise_en = 1'b0;
        start_game(12'h688, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_note", note_out, 1);
        clr_in();
        reset = 1'b1;
        #1;
        chk("mid_rst_note", note_out, 0);
        chk("mid_rst_playing", playing, 0);
        chk("mid_rst_lives", lives_left, LV);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_over", game_over, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_idle_note", note_out, 0);
            chk("mid_idle_level", level, 0);
        end

        noise_en = 1'b1;
        for (int g = 0; g < 6; g++) begin
            script_q.delete();
            start_game(MW'($urandom), 1'($urandom_range(0, 1)));
            play_game();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
